// File: rtl/c16_pkg.sv
// Shared encodings and sizing helper for the c16 multiply/divide unit.
package c16_pkg;

  typedef enum logic [1:0] {
    OP_MULU = 2'b00,
    OP_MULS = 2'b01,
    OP_DIVU = 2'b10,
    OP_DIVS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  // Bits needed to hold WIDTH-1 in the iteration counter.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/c16_muldiv_step.sv
// One iteration of shift-add multiply or restoring shift-subtract divide on a single adder.
module c16_muldiv_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] operand_i,
  input  logic [WIDTH-1:0] shreg_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] shreg_o
);

  logic [WIDTH+1:0] add_x;
  logic [WIDTH+1:0] add_y;
  logic [WIDTH+1:0] sum;
  logic [WIDTH-1:0] addend;
  logic             borrow;

  always_comb begin
    addend = shreg_i[0] ? operand_i : '0;
    if (div_i) begin
      // Divide subtracts via x + ~y + 1; the top bit of the sum flags a borrow.
      add_x = {1'b0, acc_i, shreg_i[WIDTH-1]};
      add_y = ~{2'b00, operand_i};
    end else begin
      add_x = {2'b00, acc_i};
      add_y = {2'b00, addend};
    end
    sum    = add_x + add_y + {{(WIDTH + 1){1'b0}}, div_i};
    borrow = sum[WIDTH+1];
    if (div_i) begin
      acc_o   = borrow ? add_x[WIDTH-1:0] : sum[WIDTH-1:0];
      shreg_o = {shreg_i[WIDTH-2:0], ~borrow};
    end else begin
      acc_o   = sum[WIDTH:1];
      shreg_o = {sum[0], shreg_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/c16_muldiv.sv
// Iterative signed/unsigned multiply-divide unit: start pulse in, WIDTH steps, done pulse out.
module c16_muldiv
  import c16_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter bit          ENABLE_DIV = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_lo_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic             div_by_zero_o
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [WIDTH-1:0]  operand_q, operand_d;
  logic              neg_lo_q, neg_lo_d;
  logic              neg_hi_q, neg_hi_d;
  logic              skip_q, skip_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              dbz_q, dbz_d;
  logic [WIDTH-1:0]  res_lo_q, res_lo_d;
  logic [WIDTH-1:0]  res_hi_q, res_hi_d;

  logic [WIDTH-1:0]   step_acc, step_shreg;
  logic               in_div, in_signed, in_skip;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_raw, prod;

  assign in_div    = op_i[1];
  assign in_signed = op_i[0];
  // Divide-by-zero and the divider-less build both bypass the iteration phase.
  assign in_skip   = in_div && (!ENABLE_DIV || (b_i == '0));
  assign mag_a     = (in_signed && a_i[WIDTH-1]) ? ('0 - a_i) : a_i;
  assign mag_b     = (in_signed && b_i[WIDTH-1]) ? ('0 - b_i) : b_i;
  assign prod_raw  = {acc_q, shreg_q};
  assign prod      = neg_lo_q ? ('0 - prod_raw) : prod_raw;

  c16_muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .div_i    (op_q[1] && ENABLE_DIV),
    .acc_i    (acc_q),
    .operand_i(operand_q),
    .shreg_i  (shreg_q),
    .acc_o    (step_acc),
    .shreg_o  (step_shreg)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_i) state_d = in_skip ? S_FIX : S_RUN;
      S_RUN:   if (cnt_q == '0) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_d      = op_q;
    acc_d     = acc_q;
    shreg_d   = shreg_q;
    operand_d = operand_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    skip_d    = skip_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    res_lo_d  = res_lo_q;
    res_hi_d  = res_hi_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d      = op_e'(op_i);
          acc_d     = in_skip ? a_i : '0;
          shreg_d   = mag_a;
          operand_d = mag_b;
          neg_lo_d  = in_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          neg_hi_d  = in_signed && a_i[WIDTH-1];
          skip_d    = in_skip;
          cnt_d     = CntW'(WIDTH - 1);
        end
      end
      S_RUN: begin
        acc_d   = step_acc;
        shreg_d = step_shreg;
        if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
      end
      S_FIX: begin
        done_d = 1'b1;
        if (op_q[1]) begin
          if (skip_q) begin
            res_lo_d = ENABLE_DIV ? '1 : '0;
            res_hi_d = ENABLE_DIV ? acc_q : '0;
            dbz_d    = ENABLE_DIV;
          end else begin
            res_lo_d = neg_lo_q ? ('0 - shreg_q) : shreg_q;
            res_hi_d = neg_hi_q ? ('0 - acc_q) : acc_q;
            dbz_d    = 1'b0;
          end
        end else begin
          res_lo_d = prod[WIDTH-1:0];
          res_hi_d = prod[2*WIDTH-1:WIDTH];
          dbz_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q      <= OP_MULU;
      acc_q     <= '0;
      shreg_q   <= '0;
      operand_q <= '0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      skip_q    <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      res_lo_q  <= '0;
      res_hi_q  <= '0;
    end else begin
      op_q      <= op_d;
      acc_q     <= acc_d;
      shreg_q   <= shreg_d;
      operand_q <= operand_d;
      neg_lo_q  <= neg_lo_d;
      neg_hi_q  <= neg_hi_d;
      skip_q    <= skip_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      res_lo_q  <= res_lo_d;
      res_hi_q  <= res_hi_d;
    end
  end

  always_comb begin
    busy_o        = (state_q != S_IDLE);
    done_o        = done_q;
    result_lo_o   = res_lo_q;
    result_hi_o   = res_hi_q;
    div_by_zero_o = dbz_q;
  end

endmodule

// File: tb/tb_c16_muldiv.sv
// Scoreboard bench for c16_muldiv: directed cases plus randomized ops against an arithmetic model.
module tb_c16_muldiv;

  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dbz;
    logic         skip;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_s;
  logic [1:0]   op_s;
  logic [W-1:0] a_s, b_s;
  logic         busy, done, dbz;
  logic [W-1:0] res_lo, res_hi;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  c16_muldiv #(
    .WIDTH     (W),
    .ENABLE_DIV(1'b1)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start_s),
    .op_i         (op_s),
    .a_i          (a_s),
    .b_i          (b_s),
    .busy_o       (busy),
    .done_o       (done),
    .result_lo_o  (res_lo),
    .result_hi_o  (res_hi),
    .div_by_zero_o(dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t         e;
    longint       sa, sb_, q, r;
    logic [2*W-1:0] p;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    e.dbz = 1'b0;
    e.skip = 1'b0;
    e.cyc = 0;
    case (op)
      2'b00: begin
        p = (2*W)'(a) * (2*W)'(b);
        e.lo = p[W-1:0];
        e.hi = p[2*W-1:W];
      end
      2'b01: begin
        p = (2*W)'(sa * sb_);
        e.lo = p[W-1:0];
        e.hi = p[2*W-1:W];
      end
      default: begin
        if (b == '0) begin
          e.lo = '1;
          e.hi = a;
          e.dbz = 1'b1;
          e.skip = 1'b1;
        end else if (op == 2'b10) begin
          e.lo = a / b;
          e.hi = a % b;
        end else begin
          q = sa / sb_;
          r = sa % sb_;
          e.lo = W'(q);
          e.hi = W'(r);
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest expected result and its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("result_lo", 64'(res_lo), 64'(e.lo));
        chk("result_hi", 64'(res_hi), 64'(e.hi));
        chk("div_by_zero", 64'(dbz), 64'(e.dbz));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e = model(op, a, b);
    e.cyc = cyc + 1 + (e.skip ? 1 : W + 1);
    sb.push_back(e);
    start_s = 1'b1;
    op_s = op;
    a_s = a;
    b_s = b;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    op_s = 2'($urandom);
    a_s = W'($urandom);
    b_s = W'($urandom);
    chk("busy_after_start", 64'(busy), 64'(1));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic junk_start();
    start_s = 1'b1;
    op_s = 2'($urandom);
    a_s = W'($urandom);
    b_s = W'($urandom);
    @(posedge clk);
    #1;
    start_s = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start_s = 1'b0;
    op_s = 2'b00;
    a_s = '0;
    b_s = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_lo", 64'(res_lo), 64'(0));
    chk("rst_hi", 64'(res_hi), 64'(0));
    chk("rst_dbz", 64'(dbz), 64'(0));

    issue(2'b00, 16'hFFFF, 16'hFFFF);
    wait_idle();
    issue(2'b01, 16'hFFFD, 16'h0005);
    wait_idle();
    issue(2'b11, 16'hFFF9, 16'h0002);
    wait_idle();
    issue(2'b10, 16'h0064, 16'h0000);
    wait_idle();
    issue(2'b00, 16'h0002, 16'h0003);
    wait_idle();
    issue(2'b11, 16'h8000, 16'hFFFF);
    wait_idle();
    issue(2'b10, 16'h8000, 16'h0007);
    wait_idle();

    // Start while busy must be dropped; the next start lands in the done cycle.
    issue(2'b00, 16'd5, 16'd5);
    repeat (3) @(posedge clk);
    #1;
    start_s = 1'b1;
    op_s = 2'b10;
    a_s = 16'd9;
    b_s = 16'd3;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    wait_idle();
    chk("done_in_accept_cycle", 64'(done), 64'(1));
    issue(2'b00, 16'd11, 16'd13);
    wait_idle();

    // Leave div_by_zero set, then reset mid-multiply.
    issue(2'b10, 16'h1234, 16'h0000);
    wait_idle();
    issue(2'b00, 16'd5, 16'd9);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("async_rst_busy", 64'(busy), 64'(0));
    chk("async_rst_done", 64'(done), 64'(0));
    chk("async_rst_lo", 64'(res_lo), 64'(0));
    chk("async_rst_hi", 64'(res_hi), 64'(0));
    chk("async_rst_dbz", 64'(dbz), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    issue(2'b00, 16'd7, 16'd6);
    wait_idle();

    for (int i = 0; i < 250; i++) begin
      logic [1:0]   op;
      logic [W-1:0] a, b;
      int           sel;
      wait_idle();
      if ($urandom_range(3) == 0) begin
        repeat ($urandom_range(3)) @(posedge clk);
        #1;
      end
      op = 2'($urandom_range(3));
      a = W'($urandom);
      b = W'($urandom);
      sel = $urandom_range(9);
      if (sel == 0) b = '0;
      else if (sel == 1) begin
        a = {1'b1, {(W - 1){1'b0}}};
        b = '1;
      end else if (sel == 2) b = W'(1);
      else if (sel == 3) a = {1'b1, {(W - 1){1'b0}}};
      issue(op, a, b);
      if ($urandom_range(2) == 0 && busy) junk_start();
    end

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/c16_muldiv.md
Name: c16_muldiv

Overview:
Parametrised iterative multiply/divide execution unit for the c16 core's s_xmul/s_xdiv states. The core issues one operation with a start pulse, stalls while busy, and collects the result on a single-cycle done pulse. The unit generalises to any WIDTH and supports signed and unsigned modes, with defined divide-by-zero and overflow results.

Parameters:
WIDTH, 16, operand and result-half width in bits (>= 4).
ENABLE_DIV, 1, 1 = divider present; 0 = divide ops complete in one cycle with zero results and div_by_zero=0.

Ports:
clk  in  1  clock; all state updates on posedge.
resetn  in  1  reset; asynchronous, active-low.
start  in  1  request; sampled only while busy=0.
op  in  2  00 mulu, 01 muls, 10 divu, 11 divs.
a  in  WIDTH  multiplicand / dividend; sampled with start.
b  in  WIDTH  multiplier / divisor; sampled with start.
busy  out  1  operation in flight; start is ignored.
done  out  1  one-cycle pulse; results valid from this cycle onward.
result_lo  out  WIDTH  product low half / quotient.
result_hi  out  WIDTH  product high half / remainder.
div_by_zero  out  1  last divide had b==0; valid with done.

Behaviour:
- Reset, asynchronous: state IDLE; busy, done, div_by_zero = 0; result_lo and result_hi = 0; iteration counter = 0. Reset mid-operation aborts the operation; no done is issued.
- IDLE: on start=1 at edge k:
  - latch op, |a| and |b|; magnitudes are used only for signed ops.
  - latch the result sign: for muls, sign(a)^sign(b); for divs, quotient sign sign(a)^sign(b) and remainder sign sign(a).
  - busy<=1; state<=RUN; counter<=WIDTH-1.
- RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle for exactly WIDTH cycles, edges k+1..k+WIDTH. The counter decrements; leave RUN when counter==0.
- FIX, edge k+WIDTH+1:
  - apply two's-complement negation for the sign fixup on a 2*WIDTH product or on the quotient/remainder separately.
  - drive result_lo/result_hi; done<=1; busy<=0; state<=IDLE.
- Latency: done is high for the cycle following edge k+WIDTH+1. For WIDTH=16, done is seen at edge k+18.
- Divide by zero, divu or divs with b==0: skip RUN.
  - At edge k+1: result_lo = all ones, result_hi = a (unmodified), div_by_zero=1, done=1, busy=0.
- Signed overflow, divs with a = MIN and b = -1: result_lo = MIN, result_hi = 0. This falls out of the magnitude algorithm; no special case is needed beyond verification.
- ENABLE_DIV=0 and op[1]=1: done at edge k+1 with both results 0.
- done is cleared the cycle after it is asserted. Results hold until the next accepted start overwrites them at its done.
- div_by_zero updates only at a divide's done and is cleared at a multiply's done.
- start while busy=1: ignored, with no queueing and no effect on the in-flight op.
- start in the same cycle done is high: accepted, because busy is already 0. Back-to-back throughput is WIDTH+2 cycles.
- Operand inputs may change freely after the start edge.

Decomposition:
- Shared package c16_pkg holds:
  - op encodings: OP_MULU, OP_MULS, OP_DIVU, OP_DIVS.
  - state encodings: S_IDLE, S_RUN, S_FIX.
  - the clog2-based counter width helper.
- One sub-module is natural: c16_muldiv_step, a combinational single-iteration datapath. Inputs are mode, accumulator, operand and shift register; outputs are the next accumulator and next shift register. It is shared by mul and div to keep the adder single.

Test Plan:
1. mulu a=0xFFFF b=0xFFFF at edge k -> done at k+18, result_hi=0xFFFE, result_lo=0x0001, div_by_zero=0.
2. muls a=0xFFFD (-3) b=0x0005 -> result_hi=0xFFFF, result_lo=0xFFF1; divs a=0xFFF9 (-7) b=0x0002 -> result_lo=0xFFFD, result_hi=0xFFFF.
3. divu a=0x0064 b=0x0000 -> done at k+1, result_lo=0xFFFF, result_hi=0x0064, div_by_zero=1; a following mulu 2*3 -> result_lo=6, div_by_zero=0.
4. divs a=0x8000 b=0xFFFF -> result_lo=0x8000, result_hi=0x0000; divu 0x8000/0x0007 -> result_lo=0x1249, result_hi=0x0001.
5. Start mulu 5*5; pulse start with divu 9/3 at k+4 -> ignored, single done at k+18 with result_lo=25. Then start issued in the done cycle -> accepted, second done 18 cycles later.
6. Assert resetn=0 asynchronously at k+7 mid-mul -> busy, done and results are 0 immediately; no done follows. Release, then a fresh mulu 7*6 -> result_lo=42.
